// File: rtl/route_config_builder_if.sv
// Hop stream, config word stream and control/status bundle for route_config_builder.
// slave: the builder's view; master: the router/loader/controller view.
interface route_config_builder_if;
    logic       start;
    logic       hop_valid;
    logic       hop_ready;
    logic [3:0] hop_pe;
    logic [1:0] hop_dir;
    logic       hop_first;
    logic       hop_last;
    logic       flush;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_pe;
    logic [7:0] cfg_word;
    logic       done;
    logic       error;
    logic [2:0] err_code;

    modport slave (
        input  start, hop_valid, hop_pe, hop_dir, hop_first, hop_last,
        input  flush, cfg_ready,
        output hop_ready, cfg_valid, cfg_pe, cfg_word, done, error, err_code
    );

    modport master (
        output start, hop_valid, hop_pe, hop_dir, hop_first, hop_last,
        output flush, cfg_ready,
        input  hop_ready, cfg_valid, cfg_pe, cfg_word, done, error, err_code
    );
endinterface

// File: rtl/route_config_builder.sv
// Validates XY-router hops and builds the 4x4 CGRA per-PE switch table,
// then streams it out as 16 config words. Ports: clk, reset (sync, low), bus (slave).
module route_config_builder (
    input  logic                  clk,
    input  logic                  reset,
    route_config_builder_if.slave bus
);
    localparam int GRID_W     = 4;
    localparam int NUM_PE     = GRID_W * GRID_W;
    localparam int MAX_BYPASS = 2;

    typedef enum logic [2:0] {
        S_CLEAR, S_ACCEPT, S_CHECK, S_DUMP, S_DONE
    } state_t;

    state_t     state, state_nx;
    logic [3:0] clr_idx;
    logic [3:0] mask [NUM_PE];
    logic [1:0] byp  [NUM_PE];
    logic [3:0] h_pe;
    logic [1:0] h_dir;
    logic       h_first, h_last;
    logic [3:0] prev_pe;
    logic [1:0] prev_dir;
    logic       exp_first;
    logic       err_q;
    logic [2:0] code_q;
    logic       cfg_valid_q;
    logic [3:0] cfg_pe_q;
    logic [7:0] cfg_word_q;
    logic [3:0] nb_pe;
    logic       off_grid;
    logic [2:0] chk_code;
    logic       word_acc;
    logic       last_word;

    assign word_acc  = cfg_valid_q & bus.cfg_ready;
    assign last_word = cfg_pe_q == 4'(NUM_PE - 1);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_CLEAR;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_CLEAR:  if (clr_idx == 4'(NUM_PE - 1)) state_nx = S_ACCEPT;
            S_ACCEPT: begin
                // A pending hop always beats flush.
                if (bus.hop_valid)  state_nx = S_CHECK;
                else if (bus.flush) state_nx = S_DUMP;
            end
            S_CHECK:  state_nx = S_ACCEPT;
            S_DUMP:   if (word_acc && last_word) state_nx = S_DONE;
            S_DONE:   if (bus.start) state_nx = S_CLEAR;
            default:  state_nx = S_CLEAR;
        endcase
    end

    always_comb begin
        bus.hop_ready = state == S_ACCEPT;
        bus.done      = state == S_DONE;
        bus.cfg_valid = cfg_valid_q;
        bus.cfg_pe    = cfg_pe_q;
        bus.cfg_word  = cfg_word_q;
        bus.error     = err_q;
        bus.err_code  = code_q;
    end

    // Where the previous hop of this edge must have landed.
    always_comb begin
        nb_pe = prev_pe;
        unique case (prev_dir)
            2'd3: nb_pe = prev_pe + 4'd1;
            2'd2: nb_pe = prev_pe - 4'd1;
            2'd1: nb_pe = prev_pe - 4'(GRID_W);
            2'd0: nb_pe = prev_pe + 4'(GRID_W);
            default: nb_pe = prev_pe;
        endcase
    end

    always_comb begin
        off_grid = 1'b0;
        unique case (h_dir)
            2'd3: off_grid = h_pe[1:0] == 2'd3;
            2'd2: off_grid = h_pe[1:0] == 2'd0;
            2'd1: off_grid = h_pe[3:2] == 2'd0;
            2'd0: off_grid = h_pe[3:2] == 2'd3;
            default: off_grid = 1'b0;
        endcase
    end

    // Priority order decides which code is reported for multi-fault hops.
    always_comb begin
        chk_code = 3'd0;
        if (h_first != exp_first)
            chk_code = 3'd5;
        else if (!exp_first && h_pe != nb_pe)
            chk_code = 3'd3;
        else if (off_grid)
            chk_code = 3'd4;
        else if (mask[h_pe][h_dir])
            chk_code = 3'd1;
        else if (!h_first && byp[h_pe] == 2'(MAX_BYPASS))
            chk_code = 3'd2;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_idx     <= '0;
            h_pe        <= '0;
            h_dir       <= '0;
            h_first     <= 1'b0;
            h_last      <= 1'b0;
            prev_pe     <= '0;
            prev_dir    <= '0;
            exp_first   <= 1'b1;
            err_q       <= 1'b0;
            code_q      <= '0;
            cfg_valid_q <= 1'b0;
            cfg_pe_q    <= '0;
            cfg_word_q  <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                mask[i] <= '0;
                byp[i]  <= '0;
            end
        end else begin
            case (state)
                S_CLEAR: begin
                    mask[clr_idx] <= '0;
                    byp[clr_idx]  <= '0;
                    clr_idx       <= clr_idx + 4'd1;
                end
                S_ACCEPT: begin
                    if (bus.hop_valid) begin
                        h_pe    <= bus.hop_pe;
                        h_dir   <= bus.hop_dir;
                        h_first <= bus.hop_first;
                        h_last  <= bus.hop_last;
                    end
                end
                S_CHECK: begin
                    if (chk_code == 3'd0) begin
                        mask[h_pe][h_dir] <= 1'b1;
                        if (!h_first) byp[h_pe] <= byp[h_pe] + 2'd1;
                    end else if (!err_q) begin
                        err_q  <= 1'b1;
                        code_q <= chk_code;
                    end
                    prev_pe   <= h_pe;
                    prev_dir  <= h_dir;
                    exp_first <= h_last;
                end
                S_DUMP: begin
                    // cfg_pe_q is 0 on entry, so the first word loads PE 0.
                    if (!cfg_valid_q) begin
                        cfg_valid_q <= 1'b1;
                        cfg_word_q  <= {2'b00, byp[cfg_pe_q], mask[cfg_pe_q]};
                    end else if (bus.cfg_ready) begin
                        if (last_word) begin
                            cfg_valid_q <= 1'b0;
                            cfg_pe_q    <= '0;
                            cfg_word_q  <= '0;
                        end else begin
                            cfg_pe_q   <= cfg_pe_q + 4'd1;
                            cfg_word_q <= {2'b00, byp[cfg_pe_q + 4'd1],
                                           mask[cfg_pe_q + 4'd1]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_route_config_builder.sv
// Randomised and directed bench for route_config_builder with a
// behavioural table model and a per-cycle output comparator.
module tb_route_config_builder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    route_config_builder_if bus();

    route_config_builder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nvec = 0;
    int nfail = 0;

    // Behavioural model
    logic [3:0] m_mask [16];
    int         m_byp  [16];
    bit         m_expf;
    int         m_prev_pe, m_prev_dir;
    bit         m_err;
    int         m_code;

    // Comparator state
    int         n_words = 0;
    logic [7:0] got [16];
    bit         prev_stall = 0;
    logic [3:0] prev_cpe;
    logic [7:0] prev_cw;

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_word(int k);
        logic [1:0] b;
        b = 2'(m_byp[k]);
        return {2'b00, b, m_mask[k]};
    endfunction

    function automatic void m_clear_table();
        for (int i = 0; i < 16; i++) begin
            m_mask[i] = 4'h0;
            m_byp[i]  = 0;
        end
    endfunction

    function automatic void m_clear_all();
        m_clear_table();
        m_expf = 1;
        m_prev_pe = 0;
        m_prev_dir = 0;
        m_err = 0;
        m_code = 0;
    endfunction

    function automatic int nb(int p, int d);
        case (d)
            3: return (p + 1) % 16;
            2: return (p + 15) % 16;
            1: return (p + 12) % 16;
            default: return (p + 4) % 16;
        endcase
    endfunction

    function automatic int m_check(int pe, int dir, bit first);
        int row, col;
        row = pe / 4;
        col = pe % 4;
        if (first != m_expf) return 5;
        if (!m_expf && pe != nb(m_prev_pe, m_prev_dir)) return 3;
        if ((dir == 3 && col == 3) || (dir == 2 && col == 0) ||
            (dir == 1 && row == 0) || (dir == 0 && row == 3)) return 4;
        if (m_mask[pe][dir]) return 1;
        if (!first && m_byp[pe] == 2) return 2;
        return 0;
    endfunction

    function automatic void m_apply(int pe, int dir, bit first, bit last);
        int c;
        c = m_check(pe, dir, first);
        if (c == 0) begin
            m_mask[pe][dir] = 1'b1;
            if (!first) m_byp[pe]++;
        end else if (!m_err) begin
            m_err = 1;
            m_code = c;
        end
        m_prev_pe = pe;
        m_prev_dir = dir;
        m_expf = last;
    endfunction

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset || bus.done) begin
            n_words = 0;
            prev_stall = 0;
        end
        if (reset) begin
            chk("error", int'(bus.error), int'(m_err));
            chk("err_code", int'(bus.err_code), m_code);
            if (bus.cfg_valid) begin
                if (n_words < 16) begin
                    chk("cfg_pe", int'(bus.cfg_pe), n_words);
                    chk("cfg_word", int'(bus.cfg_word), int'(m_word(n_words)));
                end else begin
                    chk("extra_word", n_words, 15);
                end
                if (prev_stall) begin
                    chk("stall_pe", int'(bus.cfg_pe), int'(prev_cpe));
                    chk("stall_word", int'(bus.cfg_word), int'(prev_cw));
                end
                if (bus.cfg_ready) begin
                    got[bus.cfg_pe] = bus.cfg_word;
                    n_words++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_cpe = bus.cfg_pe;
                    prev_cw = bus.cfg_word;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_hop_ready"}, int'(bus.hop_ready), 0);
        chk({tag, "_cfg_valid"}, int'(bus.cfg_valid), 0);
        chk({tag, "_cfg_pe"}, int'(bus.cfg_pe), 0);
        chk({tag, "_cfg_word"}, int'(bus.cfg_word), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_error"}, int'(bus.error), 0);
        chk({tag, "_err_code"}, int'(bus.err_code), 0);
    endtask

    // Enter with reset already low for at least one edge.
    task automatic release_reset();
        tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("clear_hop_ready_c16", int'(bus.hop_ready), 0);
        tick();
        chk("clear_hop_ready_c17", int'(bus.hop_ready), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.hop_valid = 0;
        bus.flush = 0;
        bus.start = 0;
        bus.cfg_ready = 0;
        m_clear_all();
        tick();
        release_reset();
    endtask

    task automatic send_hop(int pe, int dir, bit first, bit last, bit fl);
        int n = 0;
        while (!bus.hop_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.hop_ready) begin
            chk("hop_ready_timeout", 0, 1);
            return;
        end
        bus.hop_valid = 1;
        bus.hop_pe = 4'(pe);
        bus.hop_dir = 2'(dir);
        bus.hop_first = first;
        bus.hop_last = last;
        bus.flush = fl;
        tick();
        bus.hop_valid = 0;
        tick();
        m_apply(pe, dir, first, last);
    endtask

    task automatic do_dump(int stall_k, int abort_k, bit rnd);
        int n = 0;
        int stalls = 0;
        bit aborted = 0;
        for (int i = 0; i < 16; i++) got[i] = 8'hEE;
        bus.flush = 1;
        bus.cfg_ready = 1;
        while (!bus.done && n < 300 && !aborted) begin
            tick();
            n++;
            if (bus.cfg_valid) bus.flush = 0;
            if (abort_k >= 0 && bus.cfg_valid && int'(bus.cfg_pe) == abort_k) begin
                reset = 1'b0;
                bus.cfg_ready = 0;
                bus.flush = 0;
                m_clear_all();
                aborted = 1;
            end else if (bus.cfg_valid && int'(bus.cfg_pe) == stall_k && stalls < 5) begin
                bus.cfg_ready = 0;
                stalls++;
            end else begin
                bus.cfg_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
        if (aborted) begin
            tick();
            check_reset_outputs("abort");
            release_reset();
        end else begin
            chk("dump_done", int'(bus.done), 1);
            chk("dump_words", n_words, 16);
            chk("done_hop_ready", int'(bus.hop_ready), 0);
            if (stall_k >= 0) chk("stall_cycles", stalls, 5);
        end
        bus.flush = 0;
        bus.cfg_ready = 0;
    endtask

    task automatic do_start();
        bus.start = 1;
        tick();
        bus.start = 0;
        m_clear_table();
        chk("start_done_low", int'(bus.done), 0);
    endtask

    task automatic random_round(int nhops);
        int pe, dir;
        bit first, last;
        for (int i = 0; i < nhops; i++) begin
            dir = $urandom_range(0, 3);
            last = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) begin
                pe = $urandom_range(0, 15);
                first = $urandom_range(0, 1);
            end else if (m_expf) begin
                pe = $urandom_range(0, 15);
                first = 1;
            end else begin
                pe = nb(m_prev_pe, m_prev_dir);
                first = 0;
            end
            send_hop(pe, dir, first, last, 0);
        end
    endtask

    initial begin
        bus.start = 0;
        bus.hop_valid = 0;
        bus.hop_pe = 0;
        bus.hop_dir = 0;
        bus.hop_first = 0;
        bus.hop_last = 0;
        bus.flush = 0;
        bus.cfg_ready = 0;
        m_clear_all();

        // Single edge PE5 -> PE7, dump with a stall at k=3
        do_reset();
        send_hop(5, 3, 1, 0, 0);
        send_hop(6, 3, 0, 1, 0);
        do_dump(3, -1, 0);
        chk("edge_pe5", int'(got[5]), 8'h08);
        chk("edge_pe6", int'(got[6]), 8'h18);
        chk("edge_pe0", int'(got[0]), 8'h00);
        chk("edge_err", int'(bus.error), 0);

        // Port conflict
        do_start();
        send_hop(5, 3, 1, 1, 0);
        send_hop(5, 3, 1, 1, 0);
        chk("conf_err", int'(bus.error), 1);
        chk("conf_code", int'(bus.err_code), 1);
        do_dump(-1, -1, 0);
        chk("conf_pe5", int'(got[5]), 8'h08);

        // Bypass overflow at PE6
        do_reset();
        send_hop(5, 3, 1, 0, 0);
        send_hop(6, 3, 0, 1, 0);
        send_hop(7, 2, 1, 0, 0);
        send_hop(6, 2, 0, 1, 0);
        send_hop(2, 0, 1, 0, 0);
        send_hop(6, 0, 0, 1, 0);
        chk("byp_code", int'(bus.err_code), 2);
        do_dump(-1, -1, 1);
        chk("byp_pe6", int'(got[6]), 8'h2C);

        // Off-grid
        do_reset();
        send_hop(3, 3, 1, 1, 0);
        chk("offgrid_code", int'(bus.err_code), 4);

        // Non-adjacent, then a conflict that must not overwrite the code
        do_reset();
        send_hop(5, 3, 1, 0, 0);
        send_hop(9, 1, 0, 1, 0);
        chk("nonadj_code", int'(bus.err_code), 3);
        send_hop(5, 3, 1, 1, 0);
        chk("sticky_code", int'(bus.err_code), 3);
        do_dump(-1, -1, 0);

        // Hop and flush together: hop lands before the dump
        do_start();
        send_hop(10, 1, 1, 1, 1);
        do_dump(-1, -1, 0);
        chk("simul_pe10", int'(got[10]), 8'h02);

        // Randomised rounds
        do_reset();
        for (int r = 0; r < 4; r++) begin
            random_round(24);
            do_dump(-1, -1, 1);
            do_start();
        end

        // Reset mid-dump, then an empty table
        random_round(12);
        do_dump(-1, 8, 0);
        do_dump(-1, -1, 0);
        for (int i = 0; i < 16; i++) chk("post_abort_word", int'(got[i]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
